output_signature_collector: RTL
===============================

// Module: output_signature_collector
// PURPOSE
//  Response-side counterpart of the fuzz stimulus driver. Samples the DUT's wide output bus y
//  once per qualified clock and compacts the samples into a MISR signature.
//  Compares the final signature against an expected value and shifts it out serially.
//  Sits between the synthesised top and the simulation harness, so the whole run reduces to
//  one pass/fail bit and one signature.
// PARAMETERS
//  DATA_W      376           width of the sampled y bus
//  SIG_W       32            signature width; DATA_W is folded down to SIG_W
//  NUM_VECTORS 21            samples per run, range 1..2^16-1
//  POLY        32'h04C11DB7  MISR feedback polynomial (SIG_W bits)
//  SEED        32'h00000000  signature value at start of a run
// PORTS
//  clk        in   1       clock; all logic on posedge
//  rst        in   1       synchronous reset, active-high
//  start      in   1       1-cycle pulse: begin run (accepted in IDLE or DONE only)
//  y_valid    in   1       y carries a sample this cycle
//  y          in   DATA_W  DUT output bus
//  exp_sig    in   SIG_W   expected signature; sampled in the cycle the run completes
//  rd_req     in   1       1-cycle pulse: start serial readout (accepted in DONE only)
//  busy       out  1       high in CAPTURE or READOUT
//  done       out  1       high in DONE
//  match      out  1       sig == exp_sig; valid while done
//  sig        out  SIG_W   current signature register
//  count      out  16      samples absorbed in this run
//  ser_bit    out  1       serial signature bit, MSB first
//  ser_valid  out  1       ser_bit qualifier
// BEHAVIOUR
//  Reset: state=IDLE, sig=SEED, count=0, busy=done=match=ser_bit=ser_valid=0.
//    A reset mid-run or mid-readout aborts with no partial output.
//  Fold: split y into ceil(DATA_W/SIG_W) chunks starting at LSB and zero-pad the top chunk.
//    fold(y) = XOR of all chunks. For 376/32 that is 12 chunks; the top chunk holds 24 bits.
//  MISR step: sig' = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ fold(y).
//  FSM states and transitions:
//    IDLE    -start->    CAPTURE; sig<=SEED, count<=0
//    CAPTURE each y_valid cycle: MISR step, count++. The cycle count reaches NUM_VECTORS:
//            -> DONE next cycle; match<=(sig'==exp_sig) using that same cycle's exp_sig.
//            y_valid=0 cycles are ignored and do not time out. start is ignored in CAPTURE.
//    DONE    done=1; sig, match and count are held.
//            -start->  CAPTURE (restart with SEED)
//            -rd_req-> READOUT
//            start and rd_req together: start wins.
//    READOUT SIG_W cycles: ser_valid=1, ser_bit=sig[SIG_W-1-i] for i=0..SIG_W-1.
//            Then -> DONE; sig is restored unchanged (use a shadow shift register).
//            start and rd_req are ignored during READOUT.
//  Latency: first ser_valid is 1 cycle after rd_req. done rises 1 cycle after the final y_valid.
//  count is 16 bits and saturates; it never wraps within the allowed NUM_VECTORS range.
//  All outputs are registered.
// STRUCTURE
//  Shared package osc_pkg holds:
//    state encoding (IDLE=0, CAPTURE=1, DONE=2, READOUT=3)
//    default POLY/SEED constants
//    localparam NCHUNK = (DATA_W+SIG_W-1)/SIG_W
//  One sub-module, osc_fold: purely combinational DATA_W->SIG_W XOR folder, parameterised.
//  FSM, MISR, counter and shift register stay in the top module.
// TESTING
//  1 Zero data: NUM_VECTORS=1, SEED=0, y=0 -> sig=0; with exp_sig=0, match=1; done 1 cycle after sample.
//  2 Fold: y=1<<32 (chunk 1, bit 0), 1 sample -> sig=32'h00000001.
//    y=1<<375 -> sig=32'h00800000.
//  3 Shift/feedback: two samples of y=1 -> sig=32'h00000003.
//    SEED=32'h80000000 with one y=0 sample -> sig=POLY=32'h04C11DB7.
//  4 Gaps and count: NUM_VECTORS=21 with y_valid dropped on alternate cycles
//    -> count=21, done only after the 21st valid sample.
//    exp_sig wrong by one bit -> match=0.
//  5 Readout: sig=32'hA5A5A5A5, rd_req -> 32 ser_valid cycles carrying 1,0,1,0,0,1,0,1...
//    -> back to DONE with sig still A5A5A5A5. start or rd_req during READOUT has no effect.
//  6 Reset mid-CAPTURE after 5 samples -> IDLE, count=0, sig=SEED, done=0.
//    start in the same cycle as the final sample (in CAPTURE) is ignored.

Source files
------------

// File: rtl/osc_pkg.sv
// osc_pkg: shared state encoding and default constants for the output signature collector
package osc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2, READOUT = 2'd3} state_t;
  localparam int DEF_DATA_W = 376;
  localparam int DEF_SIG_W = 32;
  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'h00000000;
  localparam int NCHUNK = (DEF_DATA_W + DEF_SIG_W - 1) / DEF_SIG_W;
endpackage

// File: rtl/osc_fold.sv
// osc_fold: XOR-folds a DATA_W bus into SIG_W bits, top chunk zero-padded
module osc_fold #(
  parameter int DATA_W = 376,
  parameter int SIG_W = 32
) (
  input  logic [DATA_W-1:0] y,
  output logic [SIG_W-1:0]  f
);
  localparam int N = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int PW = N * SIG_W;
  logic [PW-1:0] pad;
  assign pad = PW'(y);
  always_comb begin
    f = '0;
    for (int i = 0; i < N; i++) f = f ^ pad[i*SIG_W +: SIG_W];
  end
endmodule

// File: rtl/output_signature_collector.sv
// output_signature_collector: MISR-compacts sampled y, compares to exp_sig, shifts signature out
module output_signature_collector
  import osc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SIG_W = DEF_SIG_W,
  parameter int NUM_VECTORS = 21,
  parameter logic [SIG_W-1:0] POLY = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              y_valid,
  input  logic [DATA_W-1:0] y,
  input  logic [SIG_W-1:0]  exp_sig,
  input  logic              rd_req,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [SIG_W-1:0]  sig,
  output logic [15:0]       count,
  output logic              ser_bit,
  output logic              ser_valid
);
  localparam int IW = $clog2(SIG_W + 2);
  state_t state, state_n;
  logic [SIG_W-1:0] f, step, sh;
  logic [IW-1:0] idx;
  logic last;
  osc_fold #(.DATA_W(DATA_W), .SIG_W(SIG_W)) u_fold (.y(y), .f(f));
  assign step = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ f;
  assign last = state == CAPTURE && y_valid && ({1'b0, count} + 17'd1 == 17'(NUM_VECTORS));
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE    ? (start ? CAPTURE : IDLE) :
              state == CAPTURE ? (last ? DONE : CAPTURE) :
              state == DONE    ? (start ? CAPTURE : rd_req ? READOUT : DONE) :
                                 (idx == IW'(SIG_W) ? DONE : READOUT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      ser_valid <= 1'b0;
      ser_bit <= 1'b0;
    end else begin
      busy <= state_n == CAPTURE || state_n == READOUT;
      done <= state_n == DONE;
      ser_valid <= state_n == READOUT;
      ser_bit <= state_n == READOUT ? (state == DONE ? sig[SIG_W-1] : sh[SIG_W-1]) : 1'b0;
    end
  end
  // sig itself is never shifted; readout works on a shadow copy so sig is untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= SEED;
      count <= '0;
      match <= 1'b0;
      sh <= '0;
      idx <= '0;
    end else begin
      if (state_n == CAPTURE && state != CAPTURE) begin
        sig <= SEED;
        count <= '0;
        match <= 1'b0;
      end else if (state == CAPTURE && y_valid) begin
        sig <= step;
        count <= count == 16'hFFFF ? count : count + 16'd1;
        if (last) match <= step == exp_sig;
      end
      if (state == DONE && state_n == READOUT) begin
        sh <= {sig[SIG_W-2:0], 1'b0};
        idx <= IW'(1);
      end else if (state == READOUT) begin
        sh <= {sh[SIG_W-2:0], 1'b0};
        idx <= idx + IW'(1);
      end
    end
  end
endmodule
